// File: rtl/dmem_lsu.sv
// Data-memory load/store unit: sits between the core M stage and a single-port
// BRAM. Stores complete in one cycle; loads stall the core for BRAM_LAT+1 cycles
// and return aligned, extended data with a one-cycle rdata_valid pulse.
module dmem_lsu #(
   parameter int unsigned ADDR_W   = 12,
   parameter int unsigned BRAM_LAT = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   input  logic              req_we,
   input  logic [31:0]       req_addr,
   input  logic [31:0]       req_wdata,
   input  logic [2:0]        req_funct3,
   output logic              stall,
   output logic [31:0]       rdata,
   output logic              rdata_valid,
   output logic              fault,
   output logic [31:0]       fault_addr,
   output logic              bram_en,
   output logic [3:0]        bram_we,
   output logic [ADDR_W-1:0] bram_addr,
   output logic [31:0]       bram_wdata,
   input  logic [31:0]       bram_rdata
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] WAIT = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   // Index of the final WAIT cycle, when bram_rdata carries the requested word.
   localparam logic [1:0] LAST_WAIT = 2'(BRAM_LAT - 1);

   logic [1:0]  state_q, state_d;
   logic [1:0]  cnt_q, cnt_d;
   logic [1:0]  addr_lo_q, addr_lo_d;
   logic [2:0]  funct3_q, funct3_d;
   logic [31:0] rdata_q, rdata_d;
   logic [31:0] fault_addr_q, fault_addr_d;

   logic        illegal, misaligned, accept, load_issue;
   logic [3:0]  we_mask;
   logic [7:0]  sel_byte;
   logic [15:0] sel_half;
   logic [31:0] ext_data;

   // Only the word-address bits reach the BRAM; the rest are don't-care here.
   logic unused_addr;
   assign unused_addr = ^req_addr;

   assign bram_addr   = req_addr[ADDR_W+1:2];
   assign rdata       = rdata_q;
   assign fault_addr  = fault_addr_q;
   assign rdata_valid = (state_q == DONE);

   // Request decode: legality, alignment and store lane/data formatting.
   always_comb begin
      illegal    = (req_funct3 == 3'b011) || (req_funct3[2] && req_funct3[1]);
      misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                   ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
      accept     = rst_n && (state_q == IDLE) && req_valid && !illegal && !misaligned;
      load_issue = accept && !req_we;
      fault      = rst_n && (state_q == IDLE) && req_valid && (illegal || misaligned);
      stall      = rst_n && (load_issue || (state_q == WAIT));
      bram_en    = accept;
      case (req_funct3[1:0])
         2'b00:   we_mask = 4'b0001 << req_addr[1:0];
         2'b01:   we_mask = req_addr[1] ? 4'b1100 : 4'b0011;
         default: we_mask = 4'b1111;
      endcase
      bram_we = (accept && req_we) ? we_mask : 4'b0000;
      case (req_funct3[1:0])
         2'b00:   bram_wdata = {4{req_wdata[7:0]}};
         2'b01:   bram_wdata = {2{req_wdata[15:0]}};
         default: bram_wdata = req_wdata;
      endcase
   end

   // Load data alignment and sign/zero extension from the captured request.
   always_comb begin
      sel_byte = bram_rdata[{addr_lo_q, 3'b000} +: 8];
      sel_half = addr_lo_q[1] ? bram_rdata[31:16] : bram_rdata[15:0];
      case (funct3_q[1:0])
         2'b00:   ext_data = {{24{sel_byte[7] & ~funct3_q[2]}}, sel_byte};
         2'b01:   ext_data = {{16{sel_half[15] & ~funct3_q[2]}}, sel_half};
         default: ext_data = bram_rdata;
      endcase
   end

   // Next-state logic: FSM, latency counter and captured load/fault info.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      addr_lo_d    = addr_lo_q;
      funct3_d     = funct3_q;
      rdata_d      = rdata_q;
      fault_addr_d = fault ? req_addr : fault_addr_q;
      case (state_q)
         IDLE: begin
            if (load_issue) begin
               state_d   = WAIT;
               cnt_d     = 2'd0;
               addr_lo_d = req_addr[1:0];
               funct3_d  = req_funct3;
            end
         end
         WAIT: begin
            if (cnt_q == LAST_WAIT) begin
               state_d = DONE;
               rdata_d = ext_data;
            end else begin
               cnt_d = cnt_q + 2'd1;
            end
         end
         // DONE ignores the still-presented request so it is not issued twice.
         default: state_d = IDLE;
      endcase
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         cnt_q        <= 2'd0;
         addr_lo_q    <= 2'd0;
         funct3_q     <= 3'd0;
         rdata_q      <= 32'd0;
         fault_addr_q <= 32'd0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         addr_lo_q    <= addr_lo_d;
         funct3_q     <= funct3_d;
         rdata_q      <= rdata_d;
         fault_addr_q <= fault_addr_d;
      end
   end

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench for dmem_lsu: one instance with BRAM_LAT=1, one with BRAM_LAT=2,
// each backed by a small behavioural BRAM. Inputs change and outputs are sampled
// just after the falling edge.
module tb_dmem_lsu;

   logic        clk = 1'b0;
   logic        rst_n;
   int          checks = 0;
   int          errors = 0;

   // Instance 1 (BRAM_LAT=1)
   logic        r_valid, r_we;
   logic [31:0] r_addr, r_wdata;
   logic [2:0]  r_f3;
   logic        stall1, rvalid1, fault1, en1;
   logic [31:0] rdata1, faddr1, wdata1, rd1;
   logic [3:0]  we1;
   logic [11:0] baddr1;
   logic [31:0] mem1 [0:3];

   // Instance 2 (BRAM_LAT=2)
   logic        r2_valid, r2_we;
   logic [31:0] r2_addr, r2_wdata;
   logic [2:0]  r2_f3;
   logic        stall2, rvalid2, fault2, en2;
   logic [31:0] rdata2, faddr2, wdata2, rd2, rd2_p;
   logic [3:0]  we2;
   logic [11:0] baddr2;
   logic [31:0] mem2 [0:3];

   always #5 clk = ~clk;

   dmem_lsu #(.ADDR_W(12), .BRAM_LAT(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .req_valid(r_valid), .req_we(r_we), .req_addr(r_addr),
      .req_wdata(r_wdata), .req_funct3(r_f3), .stall(stall1), .rdata(rdata1),
      .rdata_valid(rvalid1), .fault(fault1), .fault_addr(faddr1), .bram_en(en1),
      .bram_we(we1), .bram_addr(baddr1), .bram_wdata(wdata1), .bram_rdata(rd1)
   );

   dmem_lsu #(.ADDR_W(12), .BRAM_LAT(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .req_valid(r2_valid), .req_we(r2_we), .req_addr(r2_addr),
      .req_wdata(r2_wdata), .req_funct3(r2_f3), .stall(stall2), .rdata(rdata2),
      .rdata_valid(rvalid2), .fault(fault2), .fault_addr(faddr2), .bram_en(en2),
      .bram_we(we2), .bram_addr(baddr2), .bram_wdata(wdata2), .bram_rdata(rd2)
   );

   // One-cycle-latency BRAM with byte enables; contents preset during reset.
   always @(posedge clk) begin
      if (!rst_n) begin
         mem1[0] <= 32'h0000_0000;
         mem1[1] <= 32'h8081_F2A3;
         mem1[2] <= 32'h0000_0000;
         mem1[3] <= 32'h0000_0000;
      end else if (en1) begin
         for (int i = 0; i < 4; i++)
            if (we1[i]) mem1[baddr1[1:0]][8*i +: 8] <= wdata1[8*i +: 8];
         rd1 <= mem1[baddr1[1:0]];
      end
   end

   // Two-cycle-latency BRAM: extra output register stage.
   always @(posedge clk) begin
      if (!rst_n) begin
         mem2[0] <= 32'h8081_F2A3;
         mem2[1] <= 32'h0000_0000;
         mem2[2] <= 32'h0000_0000;
         mem2[3] <= 32'h0000_0000;
      end else if (en2) begin
         for (int i = 0; i < 4; i++)
            if (we2[i]) mem2[baddr2[1:0]][8*i +: 8] <= wdata2[8*i +: 8];
         rd2_p <= mem2[baddr2[1:0]];
      end
      rd2 <= rd2_p;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic req(input logic v, input logic we, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] wd);
      @(negedge clk);
      r_valid = v;
      r_we    = we;
      r_f3    = f3;
      r_addr  = a;
      r_wdata = wd;
      #1;
   endtask

   initial begin
      rst_n = 1'b0;
      r_valid = 1'b0; r_we = 1'b0; r_f3 = 3'b000; r_addr = 32'd0; r_wdata = 32'd0;
      r2_valid = 1'b0; r2_we = 1'b0; r2_f3 = 3'b000; r2_addr = 32'd0; r2_wdata = 32'd0;
      step();
      step();
      chk("rst_stall", 32'(stall1), 32'd0);
      chk("rst_rdata", rdata1, 32'd0);
      chk("rst_rvalid", 32'(rvalid1), 32'd0);
      chk("rst_faddr", faddr1, 32'd0);
      // Requests during reset are gated off.
      req(1'b1, 1'b1, 3'b010, 32'h0, 32'h1234_5678);
      chk("rst_gate_en", 32'(en1), 32'd0);
      chk("rst_gate_we", 32'(we1), 32'd0);
      req(1'b1, 1'b0, 3'b011, 32'h0, 32'h0);
      chk("rst_gate_fault", 32'(fault1), 32'd0);
      chk("rst_gate_stall", 32'(stall1), 32'd0);
      rst_n = 1'b1;
      req(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
      chk("idle_noreq_en", 32'(en1), 32'd0);

      // LB at 0x5 of 0x8081F2A3
      req(1'b1, 1'b0, 3'b000, 32'h5, 32'h0);
      chk("lb_issue_stall", 32'(stall1), 32'd1);
      chk("lb_issue_en", 32'(en1), 32'd1);
      chk("lb_issue_we", 32'(we1), 32'd0);
      chk("lb_issue_addr", 32'(baddr1), 32'd1);
      step();
      chk("lb_wait_stall", 32'(stall1), 32'd1);
      chk("lb_wait_en", 32'(en1), 32'd0);
      chk("lb_wait_rvalid", 32'(rvalid1), 32'd0);
      step();
      chk("lb_done_stall", 32'(stall1), 32'd0);
      chk("lb_done_rvalid", 32'(rvalid1), 32'd1);
      chk("lb_done_rdata", rdata1, 32'hFFFF_FFF2);
      chk("lb_done_en", 32'(en1), 32'd0);

      // LBU at 0x5, issued the cycle after DONE
      req(1'b1, 1'b0, 3'b100, 32'h5, 32'h0);
      chk("lbu_issue_stall", 32'(stall1), 32'd1);
      chk("lbu_rvalid_low", 32'(rvalid1), 32'd0);
      chk("lbu_rdata_held", rdata1, 32'hFFFF_FFF2);
      step();
      step();
      chk("lbu_done_rvalid", 32'(rvalid1), 32'd1);
      chk("lbu_done_rdata", rdata1, 32'h0000_00F2);

      // SH 0xBEEF at 0x6, then LW at 0x4
      req(1'b1, 1'b1, 3'b001, 32'h6, 32'h0000_BEEF);
      chk("sh_we", 32'(we1), 32'h0000_000C);
      chk("sh_wdata", wdata1, 32'hBEEF_BEEF);
      chk("sh_stall", 32'(stall1), 32'd0);
      chk("sh_en", 32'(en1), 32'd1);
      req(1'b1, 1'b0, 3'b010, 32'h4, 32'h0);
      chk("lw4_stall", 32'(stall1), 32'd1);
      step();
      step();
      chk("lw4_rdata", rdata1, 32'hBEEF_F2A3);
      chk("lw4_rvalid", 32'(rvalid1), 32'd1);

      // Faults
      req(1'b1, 1'b0, 3'b010, 32'h2, 32'h0);
      chk("lw2_fault", 32'(fault1), 32'd1);
      chk("lw2_en", 32'(en1), 32'd0);
      chk("lw2_stall", 32'(stall1), 32'd0);
      req(1'b1, 1'b0, 3'b011, 32'h0, 32'h0);
      chk("lw2_faddr", faddr1, 32'h0000_0002);
      chk("f3_011_fault", 32'(fault1), 32'd1);
      req(1'b1, 1'b1, 3'b001, 32'h3, 32'h0);
      chk("f3_011_faddr", faddr1, 32'h0000_0000);
      chk("sh3_fault", 32'(fault1), 32'd1);
      chk("sh3_we", 32'(we1), 32'd0);
      req(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
      chk("sh3_faddr", faddr1, 32'h0000_0003);
      chk("nofault", 32'(fault1), 32'd0);

      // SB, SB, LW back-to-back on word 0
      req(1'b1, 1'b1, 3'b000, 32'h0, 32'h0000_0011);
      chk("sb0_we", 32'(we1), 32'h0000_0001);
      chk("sb0_wdata", wdata1, 32'h1111_1111);
      req(1'b1, 1'b1, 3'b000, 32'h2, 32'h0000_0022);
      chk("sb2_we", 32'(we1), 32'h0000_0004);
      chk("sb2_stall", 32'(stall1), 32'd0);
      req(1'b1, 1'b0, 3'b010, 32'h0, 32'h0);
      chk("lw0_stall", 32'(stall1), 32'd1);
      step();
      step();
      chk("lw0_rdata", rdata1, 32'h0022_0011);
      chk("lw0_done_en", 32'(en1), 32'd0);
      chk("lw0_done_we", 32'(we1), 32'd0);
      req(1'b1, 1'b1, 3'b010, 32'h8, 32'hAABB_CCDD);
      chk("sw_after_done_en", 32'(en1), 32'd1);
      chk("sw_after_done_we", 32'(we1), 32'h0000_000F);
      chk("sw_after_done_stall", 32'(stall1), 32'd0);

      // Reset asserted during the WAIT cycle of a load
      req(1'b1, 1'b0, 3'b010, 32'h4, 32'h0);
      step();
      chk("rstmid_wait_stall", 32'(stall1), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("rstmid_gate_stall", 32'(stall1), 32'd0);
      @(negedge clk);
      rst_n   = 1'b1;
      r_valid = 1'b0;
      #1;
      chk("rstmid_stall", 32'(stall1), 32'd0);
      chk("rstmid_rdata", rdata1, 32'd0);
      chk("rstmid_rvalid", 32'(rvalid1), 32'd0);
      chk("rstmid_faddr", faddr1, 32'd0);
      step();
      chk("rstmid_rvalid_next", 32'(rvalid1), 32'd0);

      // BRAM_LAT=2: LH at 0x2 of 0x8081F2A3
      @(negedge clk);
      r2_valid = 1'b1;
      r2_we    = 1'b0;
      r2_f3    = 3'b001;
      r2_addr  = 32'h2;
      #1;
      chk("lat2_stall_c0", 32'(stall2), 32'd1);
      step();
      chk("lat2_stall_c1", 32'(stall2), 32'd1);
      step();
      chk("lat2_stall_c2", 32'(stall2), 32'd1);
      chk("lat2_rvalid_c2", 32'(rvalid2), 32'd0);
      step();
      chk("lat2_stall_c3", 32'(stall2), 32'd0);
      chk("lat2_rvalid_c3", 32'(rvalid2), 32'd1);
      chk("lat2_rdata", rdata2, 32'hFFFF_8081);
      r2_valid = 1'b0;
      step();
      chk("lat2_rvalid_after", 32'(rvalid2), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "timeout");
   end

endmodule
